// File: rtl/reflet_bus_arbiter_pkg.sv
// reflet_bus_arbiter_pkg: shared arbiter state encodings, default timeout and round-robin index helper.
package reflet_bus_arbiter_pkg;
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/reflet_rr_pick.sv
// reflet_rr_pick: round-robin winner selection with lock-owner override.
module reflet_rr_pick
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int masters = 2
) (
    input  logic [masters-1:0] req_i,
    input  logic [1:0]         rr_ptr_i,
    input  logic [1:0]         lock_owner_i,
    input  logic               lock_owner_valid_i,
    output logic [1:0]         winner_o,
    output logic               any_req_o
);
    // Scanning the farthest offset first lets the nearest requester after rr_ptr overwrite it.
    always_comb begin
        winner_o = rr_ptr_i;
        for (int k = masters; k >= 1; k--)
            for (int i = 0; i < masters; i++)
                if (req_i[i] && i == rr_index(int'(rr_ptr_i), k, masters)) winner_o = 2'(i);
        for (int i = 0; i < masters; i++)
            if (lock_owner_valid_i && lock_owner_i == 2'(i) && req_i[i]) winner_o = 2'(i);
    end

    assign any_req_o = |req_i;
endmodule

// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter: round-robin Reflet bus arbiter with per-master lock and per-transaction timeout.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int masters  = 2,
    parameter int timeout  = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [masters-1:0]           m_req,
    input  logic [masters-1:0]           m_lock,
    input  logic [masters*wordsize-1:0]  m_addr,
    input  logic [masters*wordsize-1:0]  m_data_out,
    input  logic [masters-1:0]           m_write_en,
    output logic [wordsize-1:0]          m_data_in,
    output logic [masters-1:0]           m_ack,
    output logic [masters-1:0]           m_err,
    output logic                         s_req,
    output logic [wordsize-1:0]          s_addr,
    output logic [wordsize-1:0]          s_data_out,
    output logic                         s_write_en,
    input  logic [wordsize-1:0]          s_data_in,
    input  logic                         s_ack,
    output logic [1:0]                   grant
);
    localparam int TW = $clog2(timeout + 1);

    logic [0:0]          state_q, state_d;
    logic [1:0]          grant_q, grant_d, rr_ptr_q, rr_ptr_d, lock_owner_q, lock_owner_d;
    logic                lock_valid_q, lock_valid_d, s_we_q, s_we_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [wordsize-1:0] s_addr_q, s_addr_d, s_data_q, s_data_d;
    logic [wordsize-1:0] addr_sel, data_sel;
    logic                we_sel, lock_sel, busy, expire, any_req;
    logic [1:0]          winner;

    reflet_rr_pick #(.masters(masters)) u_pick (
        .req_i              (m_req),
        .rr_ptr_i           (rr_ptr_q),
        .lock_owner_i       (lock_owner_q),
        .lock_owner_valid_i (lock_valid_q),
        .winner_o           (winner),
        .any_req_o          (any_req)
    );

    assign busy       = state_q == ARB_BUSY;
    assign expire     = timer_q == TW'(timeout - 1);
    assign s_req      = busy;
    assign s_write_en = s_we_q & busy;
    assign s_addr     = s_addr_q;
    assign s_data_out = s_data_q;
    assign grant      = grant_q;
    assign m_data_in  = s_data_in;

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        we_sel   = 1'b0;
        lock_sel = 1'b0;
        m_ack    = '0;
        m_err    = '0;
        for (int i = 0; i < masters; i++) begin
            if (winner == 2'(i)) begin
                addr_sel = m_addr[i*wordsize +: wordsize];
                data_sel = m_data_out[i*wordsize +: wordsize];
                we_sel   = m_write_en[i];
            end
            if (grant_q == 2'(i)) begin
                lock_sel = m_lock[i];
                m_ack[i] = busy && s_ack;
                m_err[i] = busy && !s_ack && expire;
            end
        end
    end

    // The lock only survives an IDLE cycle in which its owner wins again.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        lock_valid_d = lock_valid_q;
        timer_d      = timer_q;
        s_addr_d     = s_addr_q;
        s_data_d     = s_data_q;
        s_we_d       = s_we_q;
        if (!busy) begin
            lock_valid_d = 1'b0;
            if (any_req) begin
                state_d  = ARB_BUSY;
                grant_d  = winner;
                s_addr_d = addr_sel;
                s_data_d = data_sel;
                s_we_d   = we_sel;
                timer_d  = '0;
            end
        end else if (s_ack) begin
            state_d      = ARB_IDLE;
            rr_ptr_d     = grant_q;
            lock_owner_d = grant_q;
            lock_valid_d = lock_sel;
        end else if (expire) begin
            state_d      = ARB_IDLE;
            rr_ptr_d     = grant_q;
            lock_valid_d = 1'b0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= 2'(masters - 1);
            lock_owner_q <= '0;
            lock_valid_q <= 1'b0;
            timer_q      <= '0;
            s_addr_q     <= '0;
            s_data_q     <= '0;
            s_we_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            lock_valid_q <= lock_valid_d;
            timer_q      <= timer_d;
            s_addr_q     <= s_addr_d;
            s_data_q     <= s_data_d;
            s_we_q       <= s_we_d;
        end
    end
endmodule
